// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read sequencer.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        RESP = 2'd3
    } rd_state_t;

endpackage

// File: rtl/regfile_read_mux.sv
// Shared read mux: selects one register, with write forwarding and a
// hard-wired zero register. Purely combinational.
module regfile_read_mux
    import regfile_pkg::*;
(
    input  logic [NUM_REGS*WIDTH-1:0] reg_q,
    input  addr_t                     addr,
    input  logic                      wr_en,
    input  addr_t                     wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          data
);

    logic in_range;

    // Priority: zero register, then same-cycle write, then stored value.
    // Addresses with no backing register fall through to zero.
    always_comb begin
        data     = '0;
        in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == addr_t'(i)) begin
                data     = reg_q[i*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end
        if (in_range && wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
        if (addr == addr_t'(ZERO_REG)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_read_seq.sv
// Two-operand register read sequencer. One shared read mux is used for
// operand 1 in RD1 and operand 2 in RD2; both operands are then held
// until the consumer takes the response.
//
//  state | meaning
//  IDLE  | ready for a request; latch ra1/ra2 on req_valid
//  RD1   | capture operand 1 through the shared mux
//  RD2   | capture operand 2 through the shared mux
//  RESP  | rsp_valid high, rd1/rd2 frozen until rsp_ready
module regfile_read_seq
    import regfile_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REGS*WIDTH-1:0] reg_q,
    input  logic                      wr_en,
    input  addr_t                     wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  addr_t                     ra1,
    input  addr_t                     ra2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rd1,
    output logic [WIDTH-1:0]          rd2
);

    rd_state_t        state;
    rd_state_t        state_nx;
    addr_t            addr1;
    addr_t            addr2;
    addr_t            mux_addr;
    logic [WIDTH-1:0] mux_data;
    logic             latch_en;
    logic             cap1;
    logic             cap2;

    regfile_read_mux u_mux (
        .reg_q   (reg_q),
        .addr    (mux_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (mux_data)
    );

    // State register; async reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake outputs and capture strobes.
    // req_ready is gated by reset so it reads low while reset is held.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        latch_en  = 1'b0;
        cap1      = 1'b0;
        cap2      = 1'b0;
        mux_addr  = addr2;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (req_valid) begin
                    latch_en = 1'b1;
                    state_nx = RD1;
                end
            end
            RD1: begin
                mux_addr = addr1;
                cap1     = 1'b1;
                state_nx = RD2;
            end
            RD2: begin
                mux_addr = addr2;
                cap2     = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address latches and operand snapshots; each operand is written once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr1 <= '0;
            addr2 <= '0;
            rd1   <= '0;
            rd2   <= '0;
        end else begin
            if (latch_en) begin
                addr1 <= ra1;
                addr2 <= ra2;
            end
            if (cap1) begin
                rd1 <= mux_data;
            end
            if (cap2) begin
                rd2 <= mux_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_seq.sv
// Directed bench for regfile_read_seq.
module tb_regfile_read_seq;
    import regfile_pkg::*;

    logic                      clk;
    logic                      reset;
    logic [NUM_REGS*WIDTH-1:0] reg_q;
    logic                      wr_en;
    logic [4:0]                wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic                      req_valid;
    logic                      req_ready;
    logic [4:0]                ra1;
    logic [4:0]                ra2;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [WIDTH-1:0]          rd1;
    logic [WIDTH-1:0]          rd2;

    int n_cmp = 0;
    int n_err = 0;

    regfile_read_seq dut (
        .clk       (clk),
        .reset     (reset),
        .reg_q     (reg_q),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ra1       (ra1),
        .ra2       (ra2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd1       (rd1),
        .rd2       (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_reg(input int i, input logic [WIDTH-1:0] v);
        reg_q[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic issue(input logic [4:0] a1, input logic [4:0] a2);
        req_valid = 1'b1;
        ra1       = a1;
        ra2       = a2;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rd1 !== 64'h0) begin n_err++; $display("FAIL rst_rd1: got %h want 0", rd1); end
        n_cmp++; if (rd2 !== 64'h0) begin n_err++; $display("FAIL rst_rd2: got %h want 0", rd2); end
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
        step();
    endtask

    task automatic test_basic();
        set_reg(3, 64'h1111);
        set_reg(7, 64'h2222);
        issue(5'd3, 5'd7);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", req_ready); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", rsp_valid); end
        step();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rd1 !== 64'h1111) begin n_err++; $display("FAIL basic_rd1: got %h want 1111", rd1); end
        n_cmp++; if (rd2 !== 64'h2222) begin n_err++; $display("FAIL basic_rd2: got %h want 2222", rd2); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_zero_reg();
        set_reg(31, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(5'd31, 5'd31);
        step();
        step();
        n_cmp++; if (rd1 !== 64'h0) begin n_err++; $display("FAIL zero_rd1: got %h want 0", rd1); end
        n_cmp++; if (rd2 !== 64'h0) begin n_err++; $display("FAIL zero_rd2: got %h want 0", rd2); end
        wr_en     = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_forward();
        set_reg(5, 64'hA);
        issue(5'd5, 5'd5);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 64'hB;
        step();
        wr_data = 64'hC;
        step();
        n_cmp++; if (rd1 !== 64'hB) begin n_err++; $display("FAIL fwd_rd1: got %h want b", rd1); end
        n_cmp++; if (rd2 !== 64'hC) begin n_err++; $display("FAIL fwd_rd2: got %h want c", rd2); end
        wr_data = 64'hD;
        step();
        n_cmp++; if (rd1 !== 64'hB) begin n_err++; $display("FAIL fwd_rd1_hold: got %h want b", rd1); end
        n_cmp++; if (rd2 !== 64'hC) begin n_err++; $display("FAIL fwd_rd2_hold: got %h want c", rd2); end
        wr_en     = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        // Stored value without a concurrent write must not be forwarded.
        issue(5'd5, 5'd3);
        step();
        step();
        n_cmp++; if (rd1 !== 64'hA) begin n_err++; $display("FAIL nofwd_rd1: got %h want a", rd1); end
        n_cmp++; if (rd2 !== 64'h1111) begin n_err++; $display("FAIL nofwd_rd2: got %h want 1111", rd2); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        set_reg(10, 64'h5555_AAAA_0000_0010);
        set_reg(11, 64'h0123_4567_89AB_CDEF);
        issue(5'd10, 5'd11);
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            ra1       = 5'd3;
            ra2       = 5'd7;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", c, req_ready); end
            n_cmp++; if (rd1 !== 64'h5555_AAAA_0000_0010) begin n_err++; $display("FAIL bp_rd1[%0d]: got %h want 5555aaaa00000010", c, rd1); end
            n_cmp++; if (rd2 !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL bp_rd2[%0d]: got %h want 0123456789abcdef", c, rd2); end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_reset_midop();
        issue(5'd3, 5'd7);
        step();
        n_cmp++; if (rd1 !== 64'h1111) begin n_err++; $display("FAIL mid_pre_rd1: got %h want 1111", rd1); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rd1 !== 64'h0) begin n_err++; $display("FAIL mid_rd1: got %h want 0", rd1); end
        n_cmp++; if (rd2 !== 64'h0) begin n_err++; $display("FAIL mid_rd2: got %h want 0", rd2); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", req_ready); end
        step();
        step();
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready: got %b want 1", req_ready); end
        issue(5'd7, 5'd3);
        step();
        step();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_next_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rd1 !== 64'h2222) begin n_err++; $display("FAIL mid_next_rd1: got %h want 2222", rd1); end
        n_cmp++; if (rd2 !== 64'h1111) begin n_err++; $display("FAIL mid_next_rd2: got %h want 1111", rd2); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        set_reg(1, 64'hAAAA_0001);
        set_reg(2, 64'hBBBB_0002);
        set_reg(3, 64'hCCCC_0003);
        set_reg(4, 64'hDDDD_0004);
        req_valid = 1'b1;
        ra1       = 5'd1;
        ra2       = 5'd2;
        step();
        ra1 = 5'd3;
        ra2 = 5'd4;
        step();
        step();
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %b want 0", req_ready); end
        n_cmp++; if (rd1 !== 64'hAAAA_0001) begin n_err++; $display("FAIL b2b_first_rd1: got %h want aaaa0001", rd1); end
        n_cmp++; if (rd2 !== 64'hBBBB_0002) begin n_err++; $display("FAIL b2b_first_rd2: got %h want bbbb0002", rd2); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", rsp_valid); end
        step();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_latency: got %0d edges want 3", lat); end
        n_cmp++; if (rd1 !== 64'hCCCC_0003) begin n_err++; $display("FAIL b2b_second_rd1: got %h want cccc0003", rd1); end
        n_cmp++; if (rd2 !== 64'hDDDD_0004) begin n_err++; $display("FAIL b2b_second_rd2: got %h want dddd0004", rd2); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end_ready: got %b want 1", req_ready); end
    endtask

    initial begin
        reg_q     = '0;
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = '0;
        req_valid = 1'b0;
        ra1       = 5'd0;
        ra2       = 5'd0;
        rsp_ready = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_reg(i, 64'h7000_0000_0000_0000 | 64'(i));
        end
        test_reset();
        test_basic();
        test_zero_reg();
        test_forward();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
